reg_slice_fwd: RTL and testbench
================================

// Module: reg_slice_fwd
// PURPOSE
//  Forward-path register slice for a valid/ready stream.
//  Registers m_vld and m_pld to cut the timing path from source to sink.
//  s_rdy is combinational from m_rdy (the backward path is not registered).
//  Sits between any two valid/ready stages; full throughput, 1-cycle latency.
// PARAMETERS
//  PLD_WIDTH  32  payload width in bits (>=1)
// PORTS
//  clk    in   1          single clock; all state updates on posedge clk
//  rst_n  in   1          reset: asynchronous, active-low
//  s_vld  in   1          upstream valid
//  s_rdy  out  1          upstream ready (combinational)
//  s_pld  in   PLD_WIDTH  upstream payload
//  m_vld  out  1          downstream valid (registered)
//  m_rdy  in   1          downstream ready
//  m_pld  out  PLD_WIDTH  downstream payload (registered)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): m_vld=0 and m_pld='0 immediately.
//    s_rdy then evaluates to 1 by its equation.
//  - Release: the first transfer can be accepted at the first posedge after rst_n rises.
//  - Ready: s_rdy = ~m_vld | m_rdy.
//    The slice accepts when empty or when the current word leaves this cycle.
//  - Transfer definitions: upstream transfer = s_vld & s_rdy; downstream transfer = m_vld & m_rdy.
//  - Valid register: at posedge, if s_rdy then m_vld <= s_vld; otherwise hold.
//  - Payload register: at posedge, if s_vld & s_rdy then m_pld <= s_pld; otherwise hold.
//    The payload does not toggle on idle cycles.
//  - Latency: a word accepted at edge N appears on m_vld/m_pld after edge N and before N+1.
//  - Throughput: with m_rdy=1 continuously, one word per cycle; no bubbles.
//  - Stall: while m_vld=1 and m_rdy=0:
//    - m_vld and m_pld hold stable;
//    - s_rdy=0;
//    - s_pld changes are ignored.
//  - Simultaneous pop and push (m_vld & m_rdy & s_vld): the new word replaces the old at the same edge.
//  - Pop with no push (m_vld & m_rdy & ~s_vld): m_vld drops to 0 next cycle; m_pld keeps its last value.
//  - No combinational path from s_vld/s_pld to m_vld/m_pld.
//  - The only combinational path is m_rdy/m_vld -> s_rdy.
//  - Reset mid-stream: a held word is discarded and m_vld falls asynchronously.
//    Upstream must treat words accepted before reset as lost.
//  - Protocol contract: upstream must keep s_vld/s_pld stable until accepted.
//    The slice does not check this. Words are never duplicated or dropped.
//  - X-safety: m_vld must never be X after reset; m_pld may carry any value when m_vld=0.
// TESTING
//  (PLD_WIDTH=32; checks sampled just after posedge)
//  1. rst_n=0 with s_vld=1, s_pld=0x5 -> m_vld=0, m_pld=0, s_rdy=1;
//     release rst_n -> m_vld=1, m_pld=0x5 after the first edge.
//  2. m_rdy=1; s_vld=1 with s_pld 0x1,0x2,0x3 on consecutive edges
//     -> m_pld 0x1,0x2,0x3 one cycle later; m_vld=1 on three consecutive cycles.
//  3. Slice holds 0xA; drop m_rdy for 1 cycle while s_pld=0xB
//     -> s_rdy=0, m_pld stays 0xA; after m_rdy=1, 0xA is popped and 0xB is loaded at the same edge.
//  4. s_vld=1 for 1 cycle (0x7), then 0, with m_rdy=1
//     -> m_vld=1 for exactly 1 cycle, then 0; m_pld stays 0x7.
//  5. Slice full (0x9), m_rdy=0; assert rst_n=0 mid-cycle
//     -> m_vld falls to 0 immediately, before the next edge; 0x9 is never delivered.
//  6. Random s_vld/m_rdy for 1000 cycles with a scoreboard
//     -> output order equals input order; no loss; no duplicates; m_pld stable whenever m_vld & ~m_rdy.

Source files
------------

// File: rtl/reg_slice_fwd.sv
// Forward register slice for a valid/ready stream: m_vld/m_pld are registered,
// s_rdy is combinational from m_vld/m_rdy, giving full throughput at 1-cycle latency.
module reg_slice_fwd #(
    parameter int PLD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [PLD_WIDTH-1:0] s_pld,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [PLD_WIDTH-1:0] m_pld
);

    logic push;

    // Accept when empty or when the held word leaves at this same edge.
    assign s_rdy = ~m_vld | m_rdy;
    assign push  = s_vld & s_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
        end else if (s_rdy) begin
            m_vld <= s_vld;
        end
    end

    // Payload only moves on an upstream transfer, so idle cycles do not toggle it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pld <= '0;
        end else if (push) begin
            m_pld <= s_pld;
        end
    end

endmodule

// File: tb/tb_reg_slice_fwd.sv
// Directed and random checks of reg_slice_fwd against a queue-based model
// of a one-deep forwarding buffer.
module tb_reg_slice_fwd;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         s_vld;
    logic         s_rdy;
    logic [W-1:0] s_pld;
    logic         m_vld;
    logic         m_rdy;
    logic [W-1:0] m_pld;

    int errs;
    int checks;

    // Reference: words currently held, and the last word ever accepted.
    logic [W-1:0] q[$];
    logic [W-1:0] last_pld;
    int           pushes;
    int           dut_pops;
    bit           accepted;

    reg_slice_fwd #(.PLD_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_vld (s_vld),
        .s_rdy (s_rdy),
        .s_pld (s_pld),
        .m_vld (m_vld),
        .m_rdy (m_rdy),
        .m_pld (m_pld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_pld = '0;
    endtask

    // One clock: check s_rdy before the edge, advance model, check outputs after.
    task automatic cyc(input string tag);
        bit do_push;
        bit do_pop;
        logic [W-1:0] exp_pld;
        #1;
        chk({tag, ".s_rdy"}, W'(s_rdy), W'(q.size() == 0 || m_rdy));
        do_pop  = (q.size() != 0) && m_rdy;
        do_push = s_vld && ((q.size() == 0) || m_rdy);
        if (m_vld === 1'b1 && m_rdy) dut_pops++;
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(s_pld);
            last_pld = s_pld;
            pushes++;
        end
        accepted = do_push;
        exp_pld  = (q.size() != 0) ? q[0] : last_pld;
        chk({tag, ".m_vld"}, W'(m_vld), W'(q.size() != 0));
        chk({tag, ".m_pld"}, m_pld, exp_pld);
    endtask

    initial begin
        errs     = 0;
        checks   = 0;
        pushes   = 0;
        dut_pops = 0;
        accepted = 1'b0;
        model_reset();

        // 1: reset with a word offered, then release
        rst_n = 1'b0;
        s_vld = 1'b1;
        s_pld = 32'h5;
        m_rdy = 1'b0;
        #3;
        chk("rst.m_vld", W'(m_vld), W'(0));
        chk("rst.m_pld", m_pld, W'(0));
        chk("rst.s_rdy", W'(s_rdy), W'(1));
        #9 rst_n = 1'b1;
        cyc("t1.load");
        chk("t1.pld5", m_pld, 32'h5);
        s_vld = 1'b0;
        m_rdy = 1'b1;
        cyc("t1.drain");

        // 2: back-to-back stream, no bubbles
        s_vld = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            s_pld = W'(i);
            cyc("t2.stream");
            chk("t2.vld", W'(m_vld), W'(1));
        end
        s_vld = 1'b0;
        cyc("t2.drain");

        // 3: stall then simultaneous pop/push
        s_vld = 1'b1;
        s_pld = 32'hA;
        cyc("t3.loadA");
        m_rdy = 1'b0;
        s_pld = 32'hB;
        cyc("t3.stall");
        chk("t3.holdA", m_pld, 32'hA);
        m_rdy = 1'b1;
        cyc("t3.swap");
        chk("t3.gotB", m_pld, 32'hB);
        s_vld = 1'b0;
        cyc("t3.drain");

        // 4: single word then idle; payload must not toggle
        s_vld = 1'b1;
        s_pld = 32'h7;
        cyc("t4.load");
        s_vld = 1'b0;
        s_pld = 32'hDEAD;
        cyc("t4.pop");
        chk("t4.keep7", m_pld, 32'h7);
        cyc("t4.idle");

        // 5: full slice, async reset mid-cycle discards the held word
        s_vld = 1'b1;
        s_pld = 32'h9;
        m_rdy = 1'b0;
        cyc("t5.load9");
        s_vld = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t5.async_vld", W'(m_vld), W'(0));
        model_reset();
        #2 rst_n = 1'b1;
        m_rdy = 1'b1;
        cyc("t5.after");

        // 6: random traffic, upstream keeps the offered word stable until accepted
        pushes   = 0;
        dut_pops = 0;
        accepted = 1'b1;
        s_vld    = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (accepted || !s_vld) begin
                s_vld = ($urandom_range(0, 3) != 0);
                s_pld = $urandom;
            end
            m_rdy = ($urandom_range(0, 2) != 0);
            cyc("t6.rand");
        end
        s_vld = 1'b0;
        m_rdy = 1'b1;
        cyc("t6.flush");
        cyc("t6.flush");
        chk("t6.count", W'(dut_pops), W'(pushes));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
